s_axis_packet_rx: RTL

//   AXI4-Stream slave receiver; downstream consumer of the M_AXIS sender stage.

---
 rtl/s_axis_packet_rx.sv | 115 +++++++++++
 1 files changed

// File: rtl/s_axis_packet_rx.sv
// AXI4-Stream slave receiver: buffers beats with a per-entry last flag, caps packet
// length, counts complete buffered packets and offers them on a FWFT pop port.
module s_axis_packet_rx #(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH           = 32,
  parameter int unsigned MAX_PKT_LEN          = 32
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESETN,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
  input  logic                                S_AXIS_TLAST,
  input  logic                                pop_en,
  output logic                                empty,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     rd_data,
  output logic                                rd_last,
  output logic [$clog2(FIFO_DEPTH):0]         pkt_count,
  output logic                                len_err,
  output logic                                keep_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = C_S_AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t        state, state_nx;
  logic [15:0]   beat_cnt, beat_cnt_nx;
  logic [16:0]   cnt_inc;
  logic [DW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          active;
  logic          accept, wr_en, wr_last, force_last, pop_do, head_last;

  // active keeps TREADY low during and right after reset while staying register-only
  assign S_AXIS_TREADY = active && ((state == DROP) || (count < (AW+1)'(FIFO_DEPTH)));
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign empty         = (count == '0);
  assign pop_do        = pop_en && !empty;
  assign head_last     = mem[rd_ptr][DW];
  assign rd_last       = !empty && head_last;
  assign rd_data       = empty ? '0 : mem[rd_ptr][DW-1:0];
  assign cnt_inc       = {1'b0, beat_cnt} + 17'd1;
  assign wr_last       = S_AXIS_TLAST || force_last;

  // IDLE holds beat_cnt at 0, so IDLE and RECV share one length check
  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    wr_en       = 1'b0;
    force_last  = 1'b0;
    case (state)
      IDLE, RECV: begin
        if (accept) begin
          wr_en = 1'b1;
          if (S_AXIS_TLAST) begin
            state_nx    = IDLE;
            beat_cnt_nx = '0;
          end else if (cnt_inc == 17'(MAX_PKT_LEN)) begin
            force_last  = 1'b1;
            state_nx    = DROP;
            beat_cnt_nx = '0;
          end else begin
            state_nx    = RECV;
            beat_cnt_nx = cnt_inc[15:0];
          end
        end
      end
      DROP: begin
        if (accept && S_AXIS_TLAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      len_err   <= 1'b0;
      keep_err  <= 1'b0;
      active    <= 1'b0;
    end else begin
      active   <= 1'b1;
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_do) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({wr_en && wr_last, pop_do && head_last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
      if (force_last) len_err <= 1'b1;
      if (wr_en && (S_AXIS_TKEEP != '1)) keep_err <= 1'b1;
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (wr_en) mem[wr_ptr] <= {wr_last, S_AXIS_TDATA};
  end

endmodule
